arbitro_bus: RTL and testbench

ARBITRO_BUS -- requirements
Module: arbitro_bus

---
 rtl/arbitro_pkg.sv | 18 +
 rtl/decod_espera.sv | 25 ++
 rtl/arbitro_bus.sv | 109 ++++++++++
 tb/tb_arbitro_bus.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared types and address-map constants for the two-master bus arbiter.
// The wait-count type is sized for the 0-3 wait-state range.
package arbitro_pkg;

  typedef enum logic [1:0] {
    REPOSO,
    ACCESO,
    ESPERA,
    FIN
  } estado_t;

  typedef logic [1:0] espera_t;

  localparam logic [31:0] RAM_BASE  = 32'h0000_1000;
  localparam logic [31:0] RAM_LIMIT = 32'h0000_13FC;
  localparam logic [31:0] ROM_BASE  = 32'h0000_3000;

endpackage

// File: rtl/decod_espera.sv
// Address to wait-state lookup: RAM window, menu ROM window, zero elsewhere.
// Unmapped addresses take no wait states.
module decod_espera
  import arbitro_pkg::*;
#(
  parameter int unsigned ESPERAS_RAM = 1,
  parameter int unsigned ESPERAS_ROM = 1
) (
  input  logic [31:0] addr,
  output espera_t     esperas
);

  localparam espera_t WaitRam = espera_t'(ESPERAS_RAM);
  localparam espera_t WaitRom = espera_t'(ESPERAS_ROM);

  always_comb begin
    esperas = '0;
    if (addr >= RAM_BASE && addr <= RAM_LIMIT) begin
      esperas = WaitRam;
    end else if (addr >= ROM_BASE) begin
      esperas = WaitRom;
    end
  end

endmodule

// File: rtl/arbitro_bus.sv
// Round-robin arbiter for processor and loader/DMA masters sharing one bus,
// with per-window wait states and fully registered bus-side outputs.
module arbitro_bus
  import arbitro_pkg::*;
#(
  parameter int unsigned ESPERAS_RAM = 1,
  parameter int unsigned ESPERAS_ROM = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  ack_o,
  output logic [31:0] rdata_o,
  output logic [31:0] address_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] d_i,
  output logic        busy_o
);

  estado_t     estado;
  espera_t     cnt;
  espera_t     win_esp;
  logic        last;
  logic        we_lat;
  logic        win;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;

  // On a tie the master that was not granted last wins.
  always_comb begin
    if (req_i == 2'b11) begin
      win = ~last;
    end else begin
      win = req_i[1];
    end
    win_addr  = win ? addr1_i : addr0_i;
    win_wdata = win ? wdata1_i : wdata0_i;
  end

  decod_espera #(
    .ESPERAS_RAM(ESPERAS_RAM),
    .ESPERAS_ROM(ESPERAS_ROM)
  ) u_decod_espera (
    .addr   (win_addr),
    .esperas(win_esp)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      estado    <= REPOSO;
      cnt       <= '0;
      last      <= 1'b1;
      we_lat    <= 1'b0;
      gnt_o     <= '0;
      ack_o     <= '0;
      rdata_o   <= '0;
      address_o <= '0;
      we_o      <= 1'b0;
      wdata_o   <= '0;
      busy_o    <= 1'b0;
    end else begin
      ack_o <= '0;
      we_o  <= 1'b0;
      unique case (estado)
        REPOSO: begin
          if (|req_i) begin
            estado    <= ACCESO;
            last      <= win;
            gnt_o     <= {win, ~win};
            address_o <= win_addr;
            wdata_o   <= win_wdata;
            we_lat    <= we_i[win];
            cnt       <= win_esp;
            busy_o    <= 1'b1;
            we_o      <= we_i[win] && (win_esp == 2'd0);
          end
        end
        ACCESO, ESPERA: begin
          if (cnt == 2'd0) begin
            estado  <= FIN;
            ack_o   <= gnt_o;
            rdata_o <= d_i;
          end else begin
            estado <= ESPERA;
            cnt    <= cnt - 2'd1;
            // Strobe lands on the final wait cycle, the one before FIN.
            we_o   <= we_lat && (cnt == 2'd1);
          end
        end
        FIN: begin
          estado    <= REPOSO;
          gnt_o     <= '0;
          address_o <= '0;
          wdata_o   <= '0;
          busy_o    <= 1'b0;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_bus.sv
// Scoreboard bench for arbitro_bus: the driver queues expected completions,
// a negedge monitor checks each ack_o pulse against the queue head.
module tb_arbitro_bus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, d = '0;
  logic [1:0]  gnt, ack;
  logic [31:0] rdata, address, wdata;
  logic        we_out, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cnt = 0;
  int we_last = -1;

  typedef struct {
    logic [1:0]  ack;
    int          cyc;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          we_n;
    int          we_cyc;
  } exp_t;

  exp_t q[$];

  arbitro_bus #(
    .ESPERAS_RAM(1),
    .ESPERAS_ROM(3)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .req_i    (req),
    .we_i     (we),
    .addr0_i  (addr0),
    .addr1_i  (addr1),
    .wdata0_i (wdata0),
    .wdata1_i (wdata1),
    .gnt_o    (gnt),
    .ack_o    (ack),
    .rdata_o  (rdata),
    .address_o(address),
    .we_o     (we_out),
    .wdata_o  (wdata),
    .d_i      (d),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
    chk({tag, "_ack"}, {30'd0, ack}, 32'd0);
    chk({tag, "_we"}, {31'd0, we_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_address"}, address, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  function automatic exp_t mk(input int m, input int k, input int w, input logic [31:0] dv,
                              input logic [31:0] a, input logic [31:0] wd, input logic wr);
    exp_t e;
    e.ack    = (m == 0) ? 2'b01 : 2'b10;
    e.cyc    = k + 2 + w;
    e.rdata  = dv;
    e.addr   = a;
    e.wdata  = wd;
    e.we_n   = wr ? 1 : 0;
    e.we_cyc = k + 1 + w;
    return e;
  endfunction

  // Single isolated transaction; the address is scrambled right after grant.
  task automatic issue(input int m, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] dv, input int w);
    int k;
    k = cyc;
    d = dv;
    if (m == 0) begin
      addr0 = a; wdata0 = wd; we[0] = wr; req[0] = 1'b1;
    end else begin
      addr1 = a; wdata1 = wd; we[1] = wr; req[1] = 1'b1;
    end
    q.push_back(mk(m, k, w, dv, a, wd, wr));
    step(1);
    req = '0;
    addr0 = 32'h0000_3FF0;
    addr1 = 32'h0000_3FF0;
    step(w + 2);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (we_out) begin
        we_cnt++;
        we_last = cyc;
      end
      if (ack != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", {30'd0, ack}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("ack", {30'd0, ack}, {30'd0, e.ack});
          chk("ack_cycle", cyc, e.cyc);
          chk("gnt_at_ack", {30'd0, gnt}, {30'd0, e.ack});
          chk("busy_at_ack", {31'd0, busy}, 32'd1);
          chk("rdata", rdata, e.rdata);
          chk("address", address, e.addr);
          chk("wdata", wdata, e.wdata);
          chk("we_pulses", we_cnt, e.we_n);
          if (e.we_n == 1) chk("we_cycle", we_last, e.we_cyc);
          we_cnt = 0;
        end
      end
    end
  end

  initial begin : driver
    int k;
    step(3);
    chk_idle("reset");
    rst_n = 1'b1;
    step(1);

    // Continuous tie after reset: 01,10,01,10.
    addr0 = 32'h0000_2000; addr1 = 32'h0000_2100;
    wdata0 = 32'h1111_0000; wdata1 = 32'h2222_0000; d = 32'h0000_00C3;
    k = cyc;
    req = 2'b11;
    q.push_back(mk(0, k, 0, 32'hC3, 32'h2000, 32'h1111_0000, 1'b0));
    q.push_back(mk(1, k + 3, 0, 32'hC3, 32'h2100, 32'h2222_0000, 1'b0));
    q.push_back(mk(0, k + 6, 0, 32'hC3, 32'h2000, 32'h1111_0000, 1'b0));
    q.push_back(mk(1, k + 9, 0, 32'hC3, 32'h2100, 32'h2222_0000, 1'b0));
    step(10);
    req = '0;
    step(2);

    issue(0, 1'b0, 32'h0000_2004, 32'h0, 32'h0000_00A5, 0);
    issue(1, 1'b1, 32'h0000_1000, 32'h0000_1234, 32'h0, 1);
    issue(0, 1'b0, 32'h0000_3000, 32'h0, 32'h5A5A_0003, 3);
    issue(1, 1'b1, 32'h0000_0800, 32'hCAFE_F00D, 32'h0, 0);
    issue(0, 1'b1, 32'h0000_13FC, 32'h0BAD_BEEF, 32'h0, 1);

    // Abort a ROM write during its first wait cycle.
    addr1 = 32'h0000_3010; wdata1 = 32'h0000_0042; we = 2'b10; req = 2'b10;
    step(1);
    req = '0;
    step(1);
    rst_n = 1'b0;
    #1;
    chk_idle("abort");
    step(3);
    chk_idle("held_reset");

    // Grant on the first edge after release; pointer restarts at processor.
    rst_n = 1'b1;
    we = '0;
    addr0 = 32'h0000_2008; addr1 = 32'h0000_2100;
    wdata0 = 32'h0; wdata1 = 32'h0; d = 32'h0000_0099;
    k = cyc;
    req = 2'b11;
    q.push_back(mk(0, k, 0, 32'h99, 32'h2008, 32'h0, 1'b0));
    q.push_back(mk(1, k + 3, 0, 32'h99, 32'h2100, 32'h0, 1'b0));
    step(4);
    req = '0;
    step(2);

    // Processor drops its request after grant; loader pending is served next.
    addr0 = 32'h0000_2010; addr1 = 32'h0000_2014; d = 32'h0000_0077;
    k = cyc;
    req = 2'b01;
    q.push_back(mk(0, k, 0, 32'h77, 32'h2010, 32'h0, 1'b0));
    q.push_back(mk(1, k + 3, 0, 32'h77, 32'h2014, 32'h0, 1'b0));
    step(1);
    req = 2'b10;
    step(3);
    req = '0;
    step(2);

    for (int i = 0; i < 30; i++) begin
      if (q.size() == 0) break;
      step(1);
    end
    chk("pending_at_end", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
